// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset and waits for lock, with a timeout
// and a bounded number of retries. It then checks that lock stays up, releases
// the three downstream domain resets in a staggered order, and runs the whole
// sequence again on lock loss or when the host asks for it.
// Everything runs on the free-running reference clock.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP        = 8,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic [2:0] domain_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(RELEASE_GAP - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    retry_q;
  logic          pll_rst_q;
  logic [2:0]    dom_q;
  logic          ready_q;
  logic          fault_q;
  logic          lost_q;
  logic          sync1_q;
  logic          lock_s_q;

  // Two-flop synchronizer that brings the asynchronous PLL lock into refclk
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked;
      lock_s_q <= sync1_q;
    end
  end

  // Sequencer FSM; all outputs are registered here
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      lost_q <= 1'b0;
      if (relock_req) begin
        // A host request takes priority over everything else, but a lock loss
        // in RUN on the same cycle is still reported.
        lost_q    <= (state_q == S_RUN) && !lock_s_q;
        state_q   <= S_PLLRST;
        cnt_q     <= '0;
        retry_q   <= '0;
        pll_rst_q <= 1'b1;
        dom_q     <= '1;
        ready_q   <= 1'b0;
        fault_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_PLLRST: begin
            dom_q <= '1;
            if (cnt_q == RST_LAST) begin
              state_q   <= S_WAIT;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q     <= cnt_q + CW'(1);
              pll_rst_q <= 1'b1;
            end
          end

          S_WAIT: begin
            if (lock_s_q) begin
              state_q <= S_STABLE;
              cnt_q   <= '0;
            end else if (cnt_q == TO_LAST) begin
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
              if (retry_q == RETRY_MAX) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
              end else begin
                state_q <= S_PLLRST;
                retry_q <= retry_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_STABLE: begin
            if (!lock_s_q) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q <= S_RELEASE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_RELEASE: begin
            if (!lock_s_q) begin
              state_q   <= S_PLLRST;
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
              dom_q     <= '1;
            end else if (cnt_q == GAP_LAST) begin
              // Resets are released bit0 first. Shifting in a zero clears the
              // next bit, and dom_q[1] already being 0 means bit2 goes now.
              cnt_q <= '0;
              dom_q <= {dom_q[1:0], 1'b0};
              if (!dom_q[1]) begin
                state_q <= S_RUN;
                ready_q <= 1'b1;
                retry_q <= '0;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end

          S_RUN: begin
            if (!lock_s_q) begin
              state_q   <= S_PLLRST;
              cnt_q     <= '0;
              retry_q   <= '0;
              pll_rst_q <= 1'b1;
              dom_q     <= '1;
              ready_q   <= 1'b0;
              lost_q    <= 1'b1;
            end
          end

          S_FAULT: begin
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b1;
          end

          default: begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = dom_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign lock_lost  = lost_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters. The inputs are
// driven 1 ns after a rising edge and the outputs are sampled at the same point.
// A change on locked shows up in the FSM state three edges later: two
// synchronizer flops plus the state register.
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES    (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .RELEASE_GAP       (2),
    .MAX_RETRIES       (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .relock_req(relock_req),
    .pll_rst   (pll_rst),
    .domain_rst(domain_rst),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .retry_cnt (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_pll, input logic [2:0] e_dom,
                         input logic e_rdy, input logic e_flt, input logic e_lost,
                         input logic [3:0] e_retry);
    chk({tag, ".pll_rst"},    8'(pll_rst),    8'(e_pll));
    chk({tag, ".domain_rst"}, 8'(domain_rst), 8'(e_dom));
    chk({tag, ".ready"},      8'(ready),      8'(e_rdy));
    chk({tag, ".fault"},      8'(fault),      8'(e_flt));
    chk({tag, ".lock_lost"},  8'(lock_lost),  8'(e_lost));
    chk({tag, ".retry_cnt"},  8'(retry_cnt),  8'(e_retry));
  endtask

  initial begin
    rst        = 1'b1;
    locked     = 1'b0;
    relock_req = 1'b0;

    // Reset state
    tick(3);
    chk_all("reset", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    // Nominal: pll_rst stays high for exactly 4 edges after reset drops
    tick(3);
    chk("nom.pll_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("nom.pll_fall", 8'(pll_rst), 8'd0);
    tick(9);
    locked = 1'b1;
    // State changes 3 edges after locked rises, then 8 stable edges, then a 2-edge gap
    tick(12);
    chk("nom.pre_rel.dom", 8'(domain_rst), 8'h7);
    chk("nom.pre_rel.rdy", 8'(ready), 8'd0);
    tick(1);
    chk("nom.rel0", 8'(domain_rst), 8'h6);
    tick(1);
    chk("nom.rel0_hold", 8'(domain_rst), 8'h6);
    tick(1);
    chk("nom.rel1", 8'(domain_rst), 8'h4);
    tick(1);
    chk("nom.rel1_hold", 8'(domain_rst), 8'h4);
    tick(1);
    chk_all("nom.run", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0);

    // Lock loss in RUN: the reaction appears 3 edges later
    locked = 1'b0;
    tick(2);
    chk("loss.pre.rdy", 8'(ready), 8'd1);
    chk("loss.pre.lost", 8'(lock_lost), 8'd0);
    tick(1);
    chk_all("loss", 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 4'd0);
    tick(1);
    chk("loss.lost_pulse_end", 8'(lock_lost), 8'd0);
    chk("loss.pll1", 8'(pll_rst), 8'd1);
    tick(2);
    chk("loss.pll_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("loss.pll_fall", 8'(pll_rst), 8'd0);

    // Glitchy lock: high for 5, low for 1, then high again
    locked = 1'b1;
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    chk("glitch.pll", 8'(pll_rst), 8'd0);
    chk("glitch.retry", 8'(retry_cnt), 8'd0);
    tick(5);
    chk("glitch.no_early_rel", 8'(domain_rst), 8'h7);
    tick(5);
    chk("glitch.still_held", 8'(domain_rst), 8'h7);
    tick(1);
    chk("glitch.rel0", 8'(domain_rst), 8'h6);
    chk("glitch.rel0.pll", 8'(pll_rst), 8'd0);
    chk("glitch.rel0.retry", 8'(retry_cnt), 8'd0);
    tick(2);
    chk("glitch.rel1", 8'(domain_rst), 8'h4);
    tick(2);
    chk_all("glitch.run", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0);

    // Reset in the middle of RUN
    rst = 1'b1;
    tick(1);
    chk_all("rst_run", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;

    // Re-sequence with lock held, then relock_req while domain_rst=110
    tick(14);
    chk("rel.pre", 8'(domain_rst), 8'h7);
    tick(1);
    chk("rel.bit0", 8'(domain_rst), 8'h6);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_all("relock_rel", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0);

    // Timeout and fault: lock never comes
    locked = 1'b0;
    tick(3);
    chk("to.p1_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("to.p1_fall", 8'(pll_rst), 8'd0);
    tick(19);
    chk("to.w1_end", 8'(pll_rst), 8'd0);
    chk("to.w1_retry", 8'(retry_cnt), 8'd0);
    tick(1);
    chk("to.p2_rise", 8'(pll_rst), 8'd1);
    chk("to.p2_retry", 8'(retry_cnt), 8'd1);
    tick(3);
    chk("to.p2_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("to.p2_fall", 8'(pll_rst), 8'd0);
    tick(19);
    chk("to.w2_end", 8'(pll_rst), 8'd0);
    tick(1);
    chk("to.p3_rise", 8'(pll_rst), 8'd1);
    chk("to.p3_retry", 8'(retry_cnt), 8'd2);
    tick(3);
    chk("to.p3_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("to.p3_fall", 8'(pll_rst), 8'd0);
    tick(19);
    chk("to.w3_end.pll", 8'(pll_rst), 8'd0);
    chk("to.w3_end.fault", 8'(fault), 8'd0);
    tick(1);
    chk_all("fault", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 4'd2);
    tick(30);
    chk_all("fault_hold", 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 4'd2);

    // relock_req leaves FAULT and starts a new pll_rst pulse
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    chk_all("fault_exit", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0);
    tick(3);
    chk("fault_exit.pll_hold", 8'(pll_rst), 8'd1);
    tick(1);
    chk("fault_exit.pll_fall", 8'(pll_rst), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
